// File: rtl/ripple_count_checker.sv
// ----------------------------------------------------------------------------
// ripple_count_checker
//
// Monitors the 4-bit output of a ripple-carry counter. The raw value is
// resynchronised into the checker clock domain, and every sampled value must
// be exactly the previous sample plus one (mod 16). The checker first
// acquires lock, then tracks the sequence. While tracking it reports wrap
// events and sequence errors. After too many errors it enters a sticky
// FAULT state.
//
// Optional feature macro: RCC_CAPTURE_EN
//   defined   : exp_val/act_val latch the expected/actual value at the first
//               tracking error since reset or clr.
//   undefined : capture logic is omitted and exp_val/act_val read 4'h0.
//
// Ports
//   clk        in   checker clock (same clock as the monitored counter)
//   reset      in   asynchronous, active-low; clears all state immediately
//   clr        in   synchronous, active-high; forces re-acquisition and
//                   clears the counts (the resync chain is left running)
//   q          in   raw counter value (ripple outputs, may glitch)
//   locked     out  high while tracking the sequence
//   fault      out  high while in the sticky fault state
//   wrap_pulse out  one-cycle pulse on a tracked 15->0 step
//   wrap_count out  free-running count of wrap events (WRAP_W bits)
//   err_pulse  out  one-cycle pulse on each tracked sequence mismatch
//   err_count  out  mismatch count, saturating at 255
//   exp_val    out  expected value at the first error (optional feature)
//   act_val    out  actual value at the first error (optional feature)
// ----------------------------------------------------------------------------
module ripple_count_checker #(
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_CNT    = 4,
   parameter int ERR_LIMIT   = 3,
   parameter int WRAP_W      = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic [3:0]        q,
   output logic              locked,
   output logic              fault,
   output logic              wrap_pulse,
   output logic [WRAP_W-1:0] wrap_count,
   output logic              err_pulse,
   output logic [7:0]        err_count,
   output logic [3:0]        exp_val,
   output logic [3:0]        act_val
);

   typedef enum logic [1:0] {
      ACQUIRE = 2'd0,
      TRACK   = 2'd1,
      FAULT   = 2'd2
   } state_t;

   localparam logic [4:0] LOCK_TGT = 5'(LOCK_CNT);
   localparam logic [7:0] ERR_TGT  = 8'(ERR_LIMIT);

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic [SYNC_STAGES-1:0][3:0] sync_p0;
   logic [3:0]                  q_s;
   logic [3:0]                  prev_p1;
   logic [3:0]                  prev_inc;
   logic                        step_good;

   state_t                      state, state_n;
   logic [3:0]                  run, run_n;
   logic [4:0]                  run_inc;
   logic [WRAP_W-1:0]           wrap_count_n;
   logic [7:0]                  err_count_n;
   logic                        wrap_pulse_n;
   logic                        err_pulse_n;

   // ---- stage p0: resynchronise the glitchy ripple value ----
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_p0 <= '0;
      end else begin
         sync_p0[0] <= q;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_p0[i] <= sync_p0[i-1];
         end
      end
   end

   assign q_s = sync_p0[SYNC_STAGES-1];

   // ---- stage p1: previous sample, refreshed every cycle ----
   // Because prev always follows q_s, a single skip produces exactly one
   // mismatch rather than a cascade.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_p1 <= '0;
      end else begin
         prev_p1 <= q_s;
      end
   end

   assign prev_inc  = prev_p1 + 4'd1;
   assign step_good = (q_s == prev_inc);
   assign run_inc   = {1'b0, run} + 5'd1;

   // ---- stage p2: FSM and registered outputs ----
   always_comb begin
      state_n      = state;
      run_n        = run;
      wrap_count_n = wrap_count;
      err_count_n  = err_count;
      wrap_pulse_n = 1'b0;
      err_pulse_n  = 1'b0;
      if (clr) begin
         state_n      = ACQUIRE;
         run_n        = '0;
         wrap_count_n = '0;
         err_count_n  = '0;
      end else begin
         case (state)
            ACQUIRE: begin
               if (step_good) begin
                  if (run_inc >= LOCK_TGT) begin
                     state_n = TRACK;
                     run_n   = '0;
                  end else begin
                     run_n = run_inc[3:0];
                  end
               end else begin
                  run_n = '0;
               end
            end
            TRACK: begin
               if (step_good) begin
                  if (prev_p1 == 4'hF) begin
                     wrap_pulse_n = 1'b1;
                     wrap_count_n = wrap_count + WRAP_W'(1);
                  end
               end else begin
                  err_pulse_n = 1'b1;
                  err_count_n = sat_inc(err_count);
                  if (err_count_n >= ERR_TGT) begin
                     state_n = FAULT;
                  end
               end
            end
            FAULT: begin
               // sticky: only clr or reset leave this state
            end
            default: begin
               state_n = ACQUIRE;
               run_n   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ACQUIRE;
         run        <= '0;
         locked     <= 1'b0;
         fault      <= 1'b0;
         wrap_pulse <= 1'b0;
         err_pulse  <= 1'b0;
         wrap_count <= '0;
         err_count  <= '0;
      end else begin
         state      <= state_n;
         run        <= run_n;
         locked     <= (state_n == TRACK);
         fault      <= (state_n == FAULT);
         wrap_pulse <= wrap_pulse_n;
         err_pulse  <= err_pulse_n;
         wrap_count <= wrap_count_n;
         err_count  <= err_count_n;
      end
   end

`ifdef RCC_CAPTURE_EN
   // First tracking error only; later errors leave the capture untouched.
   logic captured;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         captured <= 1'b0;
         exp_val  <= 4'h0;
         act_val  <= 4'h0;
      end else if (clr) begin
         captured <= 1'b0;
         exp_val  <= 4'h0;
         act_val  <= 4'h0;
      end else if ((state == TRACK) && !step_good && !captured) begin
         captured <= 1'b1;
         exp_val  <= prev_inc;
         act_val  <= q_s;
      end
   end
`else
   assign exp_val = 4'h0;
   assign act_val = 4'h0;
`endif

endmodule
